// File: rtl/autotune_pkg.sv
// Shared constants and types for the pitch-detection front end.
package autotune_pkg;

  localparam int SAMPLE_WIDTH = 32;
  localparam int WINDOW_SIZE  = 2048;

  typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_DRAIN} frame_rd_state_t;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port sample RAM holding both ping-pong banks; the bank bit is the
// address MSB. Registered read, one cycle of latency.
module frame_bank_ram
  import autotune_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH,
  parameter int AW    = $clog2(WINDOW_SIZE) + 1
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/frame_buffer.sv
// Ping-pong window buffer: fills one bank from strobed samples while the other
// bank is replayed as a ready/valid stream through a 2-entry skid buffer.
module frame_buffer
  import autotune_pkg::*;
#(
  parameter int WIDTH  = SAMPLE_WIDTH,
  parameter int DEPTH  = WINDOW_SIZE,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic signed [WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [ADDR_W-1:0]       dout_idx,
  output logic                    dout_last,
  output logic                    overflow
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic              r_wbank;
  logic [ADDR_W-1:0] r_widx;
  logic [1:0]        r_full;
  logic [1:0]        w_full_nxt;
  logic              r_overflow;
  logic              w_wbank_blocked;
  logic              w_wr;
  logic              w_wr_done;

  frame_rd_state_t   r_state;
  frame_rd_state_t   w_state_nxt;
  logic              r_rbank;
  logic              w_rbank_nxt;
  logic [ADDR_W-1:0] r_ridx;
  logic [ADDR_W-1:0] w_ridx_nxt;
  logic              w_rd_en;
  logic              w_rd_bank;
  logic [ADDR_W-1:0] w_rd_idx;

  logic                    r_vld_p1;
  logic [ADDR_W-1:0]       r_idx_p1;
  logic [WIDTH-1:0]        w_ram_q;
  logic signed [WIDTH-1:0] w_q_p1;

  logic [1:0]              r_cnt_p2;
  logic signed [WIDTH-1:0] r_sk_d_p2 [2];
  logic [ADDR_W-1:0]       r_sk_i_p2 [2];
  logic                    w_push;
  logic                    w_pop;
  logic                    w_push_slot;
  logic                    w_room;
  logic                    w_accept;
  logic                    w_free;

  // A bank freed this cycle is writable this cycle, so a HOLD exit never drops a sample.
  assign w_wbank_blocked = r_full[r_wbank] & ~(w_free & (r_rbank == r_wbank));
  assign w_wr            = sample_valid & ~w_wbank_blocked;
  assign w_wr_done       = w_wr & (r_widx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbank    <= 1'b0;
      r_widx     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= sample_valid & w_wbank_blocked;
      if (w_wr) begin
        if (w_wr_done) begin
          r_widx  <= '0;
          r_wbank <= ~r_wbank;
        end else begin
          r_widx <= r_widx + ADDR_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_free) w_full_nxt[r_rbank] = 1'b0;
    if (w_wr_done) w_full_nxt[r_wbank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_full <= 2'b00;
    else     r_full <= w_full_nxt;
  end

  // Banks are filled and replayed in the same alternating order, so the reader
  // simply toggles its bank after each window.
  always_comb begin
    w_state_nxt = r_state;
    w_rbank_nxt = r_rbank;
    w_ridx_nxt  = r_ridx;
    w_rd_en     = 1'b0;
    w_rd_bank   = r_rbank;
    w_rd_idx    = r_ridx;
    case (r_state)
      RD_IDLE: begin
        w_ridx_nxt = '0;
        if (r_full[r_rbank]) w_state_nxt = RD_READ;
      end
      RD_READ: begin
        if (w_room) begin
          w_rd_en = 1'b1;
          if (r_ridx == LAST_IDX) begin
            w_state_nxt = RD_DRAIN;
            w_ridx_nxt  = '0;
          end else begin
            w_ridx_nxt = r_ridx + ADDR_W'(1);
          end
        end
      end
      RD_DRAIN: begin
        if (w_free) begin
          w_rbank_nxt = ~r_rbank;
          if (r_full[~r_rbank]) begin
            w_state_nxt = RD_READ;
            w_ridx_nxt  = '0;
            if (w_room) begin
              w_rd_en    = 1'b1;
              w_rd_bank  = ~r_rbank;
              w_rd_idx   = '0;
              w_ridx_nxt = ADDR_W'(1);
            end
          end else begin
            w_state_nxt = RD_IDLE;
          end
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RD_IDLE;
      r_rbank <= 1'b0;
      r_ridx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rbank <= w_rbank_nxt;
      r_ridx  <= w_ridx_nxt;
    end
  end

  frame_bank_ram #(
    .WIDTH (WIDTH),
    .AW    (ADDR_W + 1)
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (w_wr),
    .i_wr_addr ({r_wbank, r_widx}),
    .i_wr_data (sample_in),
    .i_rd_en   (w_rd_en),
    .i_rd_addr ({w_rd_bank, w_rd_idx}),
    .o_rd_data (w_ram_q)
  );

  // p0 -> p1: read issue to registered RAM output
  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= w_rd_en;
  end

  always_ff @(posedge clk) begin
    if (w_rd_en) r_idx_p1 <= w_rd_idx;
  end

  assign w_q_p1 = w_ram_q;

  // p1 -> p2: skid entries; the RAM output bypasses them when they are empty
  assign w_accept    = dout_valid & dout_ready;
  assign w_pop       = (r_cnt_p2 != 2'd0) & dout_ready;
  assign w_push      = r_vld_p1 & ~((r_cnt_p2 == 2'd0) & dout_ready);
  assign w_push_slot = (r_cnt_p2 == 2'd2) | ((r_cnt_p2 == 2'd1) & ~w_pop);
  assign w_room      = (r_cnt_p2 == 2'd0) | ((r_cnt_p2 == 2'd1) & ~r_vld_p1);

  always_ff @(posedge clk) begin
    if (rst) r_cnt_p2 <= 2'd0;
    else     r_cnt_p2 <= r_cnt_p2 + {1'b0, w_push} - {1'b0, w_pop};
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_sk_d_p2[0] <= r_sk_d_p2[1];
      r_sk_i_p2[0] <= r_sk_i_p2[1];
    end
    if (w_push) begin
      r_sk_d_p2[w_push_slot] <= w_q_p1;
      r_sk_i_p2[w_push_slot] <= r_idx_p1;
    end
  end

  assign dout_valid = (r_cnt_p2 != 2'd0) | r_vld_p1;
  assign dout       = (r_cnt_p2 != 2'd0) ? r_sk_d_p2[0] : (r_vld_p1 ? w_q_p1 : '0);
  assign dout_idx   = (r_cnt_p2 != 2'd0) ? r_sk_i_p2[0] : (r_vld_p1 ? r_idx_p1 : '0);
  assign dout_last  = dout_valid & (dout_idx == LAST_IDX);
  assign w_free     = (r_state == RD_DRAIN) & w_accept & dout_last;
  assign overflow   = r_overflow;

endmodule
